// File: rtl/masked_and_dom_pipe.sv
`default_nettype none
// ============================================================================
// Module   : masked_and_dom_pipe
// Function : DOM-indep masked AND gadget with valid/ready flow control.
//            Optional macro MASKED_AND_OUT_REG_EN adds a registered output stage.
// Revision : 1.0 - initial release
// ============================================================================
module masked_and_dom_pipe #(
  parameter int NUM_SHARES    = 3,
  parameter int WIDTH         = 8,
  parameter int NUM_QUADRATIC = NUM_SHARES * (NUM_SHARES - 1) / 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [NUM_SHARES*WIDTH-1:0]    a_i,
  input  logic [NUM_SHARES*WIDTH-1:0]    b_i,
  input  logic [NUM_QUADRATIC*WIDTH-1:0] r_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [NUM_SHARES*WIDTH-1:0]    q_o
);

  localparam int C_NUM_CROSS = NUM_SHARES * (NUM_SHARES - 1);

  // Row-major index of the unordered pair {i,j}; symmetric in its arguments.
  function automatic int qindex(input int i, input int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * NUM_SHARES - lo * (lo + 1) / 2 + (hi - lo - 1);
  endfunction

  // Dense index of the ordered pair (i,j), i != j; the diagonal maps to 0 unused.
  function automatic int cindex(input int i, input int j);
    int col;
    if (j < i)      col = j;
    else if (j > i) col = j - 1;
    else            col = 0;
    return i * (NUM_SHARES - 1) + col;
  endfunction

  logic                          w_accept;
  logic                          r_v1;
  logic [NUM_SHARES*WIDTH-1:0]   w_inner;
  logic [C_NUM_CROSS*WIDTH-1:0]  w_cross;
  logic [NUM_SHARES*WIDTH-1:0]   r_inner;
  logic [C_NUM_CROSS*WIDTH-1:0]  r_cross;
  logic [NUM_SHARES*WIDTH-1:0]   w_q;

  assign w_accept = in_valid_i & in_ready_o;

  generate
    for (genvar i = 0; i < NUM_SHARES; i++) begin : g_row
      assign w_inner[i*WIDTH +: WIDTH] = a_i[i*WIDTH +: WIDTH] & b_i[i*WIDTH +: WIDTH];
      for (genvar j = 0; j < NUM_SHARES; j++) begin : g_col
        if (i != j) begin : g_cross
          assign w_cross[cindex(i, j)*WIDTH +: WIDTH] =
            (a_i[i*WIDTH +: WIDTH] & b_i[j*WIDTH +: WIDTH]) ^ r_i[qindex(i, j)*WIDTH +: WIDTH];
        end
      end
    end
  endgenerate

  // Stage-1 registers only move on accept, so randomness is spent once per transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_inner <= '0;
      r_cross <= '0;
    end else if (w_accept) begin
      r_inner <= w_inner;
      r_cross <= w_cross;
    end
  end

  // Compression reads registered terms only, so no share domain meets unmasked.
  generate
    for (genvar k = 0; k < NUM_SHARES; k++) begin : g_comp
      logic [WIDTH-1:0] w_acc;
      always_comb begin
        w_acc = r_inner[k*WIDTH +: WIDTH];
        for (int j = 0; j < NUM_SHARES; j++) begin
          if (j != k) begin
            w_acc = w_acc ^ r_cross[cindex(k, j)*WIDTH +: WIDTH];
          end
        end
      end
      assign w_q[k*WIDTH +: WIDTH] = w_acc;
    end
  endgenerate

`ifdef MASKED_AND_OUT_REG_EN
  logic                        r_v2;
  logic [NUM_SHARES*WIDTH-1:0] r_q;
  logic                        w_s2_load;

  assign w_s2_load  = r_v1 & (~r_v2 | out_ready_i);
  assign in_ready_o = ~r_v1 | ~r_v2 | out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_q  <= '0;
    end else begin
      r_v1 <= w_accept | (r_v1 & ~w_s2_load);
      r_v2 <= w_s2_load | (r_v2 & ~out_ready_i);
      if (w_s2_load) begin
        r_q <= w_q;
      end
    end
  end

  assign out_valid_o = r_v2;
  assign q_o         = r_q;
`else
  assign in_ready_o = ~r_v1 | out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= w_accept | (r_v1 & ~out_ready_i);
    end
  end

  assign out_valid_o = r_v1;
  assign q_o         = w_q;
`endif

endmodule
`default_nettype wire
